// File: rtl/pst_pkg.sv
// Shared symbol definitions for the serial link (transmitter and receiver side).
package pst_pkg;

    localparam int SYM_W = 8;
    localparam int CNT_W = $clog2(SYM_W);

    localparam logic [SYM_W-1:0] COM_SYM_DEF  = 8'hBC;
    localparam logic [SYM_W-1:0] IDLE_SYM_DEF = 8'h7C;

    typedef enum logic {
        INIT,
        ACTIVE
    } pst_state_e;

endpackage

// File: rtl/pst_if.sv
// Byte-wide valid/ready port feeding the serial transmitter.
interface pst_if;
    import pst_pkg::*;

    logic [SYM_W-1:0] data_in;
    logic             valid_in;
    logic             ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);

endinterface

// File: rtl/pst_shift_reg.sv
// MSB-first symbol shifter: reloads every SYM_W clocks, shifts left otherwise.
module pst_shift_reg
    import pst_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             load_o,
    output logic             data_o,
    output logic             byte_start_o
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);

    logic [SYM_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign load_o = (bit_cnt_q == LAST_BIT);

    always_comb begin
        shreg_d   = {shreg_q[SYM_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (load_o) begin
            shreg_d   = sym_i;
            bit_cnt_d = '0;
        end
    end

    // Counter parks on the last bit in reset so the first edge afterwards loads a symbol.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q   <= '0;
            bit_cnt_q <= LAST_BIT;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign data_o       = shreg_q[SYM_W-1];
    assign byte_start_o = (bit_cnt_q == '0) && !rst_i;

endmodule

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial link transmitter: COM alignment burst, then data or IDLE fill.
// Optional build macro PST_BYTE_CNT_EN adds the tx_byte_count output.
module paralelo_serial_tx
    import pst_pkg::*;
#(
    parameter logic [SYM_W-1:0] COM_SYM   = COM_SYM_DEF,
    parameter logic [SYM_W-1:0] IDLE_SYM  = IDLE_SYM_DEF,
    parameter int               COM_COUNT = 4
) (
    input  logic    clk_32f,
    input  logic    reset,
    pst_if.slave    tx_if,
    output logic    data_out,
    output logic    byte_start,
    output logic    active_out,
    output logic    idle_out
`ifdef PST_BYTE_CNT_EN
    ,
    output logic [15:0] tx_byte_count
`endif
);

    localparam logic [3:0] COM_LAST = 4'(COM_COUNT - 1);

    pst_state_e       state_q, state_d;
    logic [3:0]       com_cnt_q, com_cnt_d;
    logic [SYM_W-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             idle_q, idle_d;
    logic             active_q, active_d;
    logic [SYM_W-1:0] sym_d;
    logic             load;
    logic             accept;

    assign tx_if.ready_out = !buf_full_q;
    assign accept          = tx_if.valid_in && !buf_full_q;

    pst_shift_reg u_shift (
        .clk_i        (clk_32f),
        .rst_i        (reset),
        .sym_i        (sym_d),
        .load_o       (load),
        .data_o       (data_out),
        .byte_start_o (byte_start)
    );

    // Accept and drain are exclusive: one needs an empty buffer, the other a full one.
    always_comb begin
        state_d    = state_q;
        com_cnt_d  = com_cnt_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        idle_d     = idle_q;
        active_d   = active_q;
        sym_d      = COM_SYM;

        if (accept) begin
            buf_d      = tx_if.data_in;
            buf_full_d = 1'b1;
        end

        case (state_q)
            INIT: begin
                if (load) begin
                    if (com_cnt_q == COM_LAST) state_d = ACTIVE;
                    else                       com_cnt_d = com_cnt_q + 4'd1;
                end
            end
            ACTIVE: begin
                sym_d = buf_full_q ? buf_q : IDLE_SYM;
                if (load) begin
                    active_d = 1'b1;
                    if (buf_full_q) begin
                        buf_full_d = 1'b0;
                        idle_d     = 1'b0;
                    end else begin
                        idle_d     = 1'b1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= INIT;
            com_cnt_q  <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            idle_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            com_cnt_q  <= com_cnt_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
        end
    end

    assign active_out = active_q;
    assign idle_out   = idle_q;

`ifdef PST_BYTE_CNT_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;

    // Only bytes drained from the holding buffer count; wraps naturally at 16 bits.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (state_q == ACTIVE && load && buf_full_q) byte_cnt_d = byte_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) byte_cnt_q <= '0;
        else       byte_cnt_q <= byte_cnt_d;
    end

    assign tx_byte_count = byte_cnt_q;
`endif

endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
Parallel-to-serial transmitter for the serial link: the transmit-side counterpart to the serial-to-parallel receiver.
- Takes bytes through a valid/ready port and shifts them out MSB-first on clk_32f, one bit per clock and 8 clocks per byte.
- After reset, sends COM_COUNT comma symbols (0xBC) so the far-end receiver can align, then enters ACTIVE.
- In ACTIVE, sends buffered data, or the IDLE symbol (0x7C) when no byte is pending.

Parameters:
COM_SYM, 8'hBC, comma/alignment symbol sent during INIT
IDLE_SYM, 8'h7C, filler symbol sent in ACTIVE when no byte is pending
COM_COUNT, 4, number of COM symbols sent after reset (legal range 1..15)

Ports:
clk_32f  in  1  bit clock; one serial bit per rising edge
reset  in  1  asynchronous, active-high reset
data_in  in  8  parallel byte to transmit
valid_in  in  1  data_in is valid
ready_out  out  1  holding buffer can accept a byte; a transfer happens on an edge where valid_in && ready_out
data_out  out  1  serial bit stream, MSB first
byte_start  out  1  high while data_out carries bit 7 of a symbol
active_out  out  1  link is in ACTIVE; symbols are data or IDLE
idle_out  out  1  the symbol currently on data_out is IDLE_SYM inserted by this block

Behaviour:
Clock and reset:
- One clock, clk_32f. reset is asynchronous and active-high.
- While reset is high: bit_cnt=7, shreg=0, buf=0, buf_full=0, com_cnt=0, state=INIT.
- Outputs while reset is high: data_out=0, byte_start=0, active_out=0, idle_out=0, ready_out=1.
- Reset asserted mid-byte aborts the current symbol immediately; there is no flush.

Shifter and symbol load:
- data_out = shreg[7], so it is registered.
- At each edge: if bit_cnt==7, load the next symbol into shreg and set bit_cnt=0; otherwise shift shreg left by one and increment bit_cnt.
- byte_start = (bit_cnt==0) && !reset.
- The first edge after reset release loads COM_SYM, so data_out=1 on that cycle.

INIT state:
- Each load writes COM_SYM into shreg.
- If com_cnt==COM_COUNT-1, state goes to ACTIVE; otherwise com_cnt increments.
- Exactly COM_COUNT COM symbols are sent (8*COM_COUNT clocks).

ACTIVE state:
- At a load edge with buf_full=1: shreg<=buf, buf_full<=0, idle_out<=0.
- At a load edge with buf_full=0: shreg<=IDLE_SYM, idle_out<=1.
- active_out<=1 on the first load edge taken in ACTIVE, so it rises together with the first post-COM symbol. It stays 1 until reset.
- There is no return to INIT except through reset.

Holding buffer (1 entry):
- ready_out = !buf_full. This is combinational from the register.
- Accept on valid_in && ready_out: buf<=data_in, buf_full<=1.
- Bytes are accepted during INIT and held until the first ACTIVE load.
- Simultaneous load-edge drain and new accept cannot occur, because ready_out=0 while the buffer is full. A byte accepted on a load edge with the buffer empty is sent as the next symbol, not the current one (IDLE is loaded that edge).
- Throughput: at most one byte per 8 clocks. Latency from accept to its first bit on data_out is 1..8 clocks, set by bit_cnt phase.
- data_in and valid_in are ignored while ready_out=0; the bench must hold the byte.

Optional Feature:
PST_BYTE_CNT_EN:
- Defined: adds output tx_byte_count[15:0], reset to 0. It increments on each ACTIVE load edge that takes a byte from buf, and wraps 0xFFFF -> 0x0000. IDLE and COM symbols are not counted.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package pst_pkg: COM_SYM/IDLE_SYM default constants, the state enum {INIT, ACTIVE}, and symbol width 8. The same package is used by the receiver-side comma/idle detection.
- Natural sub-module: pst_shift_reg (8-bit load/shift register plus bit_cnt, outputs data_out/byte_start). The FSM and holding buffer stay in the top module.

Test Plan:
- Reset released, valid_in=0, COM_COUNT=4 -> data_out = 10111100 repeated 4 times (32 clocks); active_out=0 throughout, then rises with the next symbol, which is 01111100 with idle_out=1.
- In ACTIVE, push 0xA5 one clock after byte_start -> ready_out drops the next clock; the next symbol serialises as 10100101 with idle_out=0; ready_out returns high on that load edge.
- Push 0x3C then 0xC3 back-to-back (valid_in held) -> symbols 0x3C, 0xC3 sent consecutively with no IDLE between; ready_out low for exactly 8 clocks between the two accepts.
- Push 0x55 during INIT -> byte held (ready_out=0) and sent as the first ACTIVE symbol; no IDLE precedes it.
- Assert reset at bit 3 of a data byte -> data_out=0, ready_out=1, active_out=0 asynchronously; after release the COM sequence restarts from bit 7 and the buffered byte is lost.
- With PST_BYTE_CNT_EN defined, send 5 data bytes interleaved with IDLEs -> tx_byte_count=5. Preload the counter to 0xFFFF via force, send 1 byte -> tx_byte_count=0x0000.
